mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
Parametrised MEM/WB pipeline register for the pipelined CPU. It sits between the memory stage and register-file writeback.
- Replaces the always-transparent latch with a clocked, stallable, flushable stage using a valid/ready handshake and a 2-entry skid buffer.
- Adds a built-in writeback mux and write-enable generation.
- Data width and register-address width are generic.

Parameters:
DATA_W, 8, width of ALU result and memory read data
RADDR_W, 3, width of destination register address
WB_ON_HANDSHAKE, 1, 1: wb_en only when out_valid & out_ready; 0: wb_en whenever out_valid

Ports:
clk2  in  1  stage clock, all state changes on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  discard all held and incoming entries
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept an entry this cycle
alu_out  in  DATA_W  ALU result from memory stage
mem_out  in  DATA_W  data-memory read data
MemToReg  in  1  writeback select, 1 = memory data
RegWrite  in  1  entry writes the register file
rd_addr  in  RADDR_W  destination register
out_valid  out  1  held entry valid
out_ready  in  1  writeback can consume the entry
alu_in  out  DATA_W  registered ALU result
mem_in  out  DATA_W  registered memory data
MemToRegmux  out  1  registered writeback select
wb_data  out  DATA_W  MemToRegmux ? mem_in : alu_in
wb_addr  out  RADDR_W  registered rd_addr
wb_en  out  1  register-file write strobe

Behaviour:
- State: main register (M) plus skid register (S), each with its own valid bit (m_v, s_v). All outputs are driven from M.
- Reset (rst high at an edge): m_v=0, s_v=0, all payload regs=0.
  - So out_valid=0, wb_en=0, wb_data=0, alu_in=0, mem_in=0, MemToRegmux=0, wb_addr=0.
  - in_ready=1 from the first cycle after reset. rst takes priority over flush and every handshake.
- in_ready = !s_v, driven directly from the register with no combinational path from out_ready.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Per edge (no rst, no flush):
  - M empty or draining, S valid: M<=S, s_v<=0. If accepting in the same cycle, the new entry goes to M only when S was empty; otherwise it goes to S.
  - M empty or draining, S empty, accept: M<=input, m_v<=1.
  - M empty or draining, nothing to load: m_v<=0.
  - M full, not draining, accept: S<=input, s_v<=1. in_ready drops to 0 the next cycle.
- Latency: input accepted at edge N is visible on the outputs after edge N (1 cycle) when S is empty. Throughput is 1 entry/cycle with continuous out_ready.
- Ordering is strictly FIFO. No entry is ever duplicated or lost except by flush or rst.
- Flush: at the edge, m_v<=0 and s_v<=0, and any entry accepted in that cycle is dropped. Payload regs may hold stale data, but wb_en must be 0. The next cycle in_ready=1.
- wb_en:
  - WB_ON_HANDSHAKE=1: out_valid & out_ready & RegWrite of M.
  - WB_ON_HANDSHAKE=0: out_valid & RegWrite of M.
  - Always 0 when out_valid=0.
- wb_data is combinational from M. There is no arithmetic and no width change.
- Payload must not change while out_valid=1 and out_ready=0.
- Simultaneous full and draining (M full, S full, out_ready=1): M<=S, s_v<=0, in_ready=1 next cycle. No input is accepted that cycle because in_ready=0.
- No # delays inside the block; the stage is fully synchronous to clk2.

Decomposition:
- Shared package cpu_pipe_pkg: DATA_W and RADDR_W defaults, and the packed stage-payload struct {alu, mem, memtoreg, regwrite, rd}. The later IF/ID/EX stages reuse the same package.
- One natural sub-module: pipe_skid_reg, a generic 2-entry valid/ready skid buffer parametrised on payload width. mem_wb_stage instantiates it and adds the writeback mux and wb_en logic.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then 0 -> out_valid=0, wb_en=0, in_ready=1, all data outputs 0x00.
- Streaming: out_ready=1, feed alu_out=0x11,0x22,0x33 with MemToReg=0, RegWrite=1, rd=1,2,3 -> one cycle later wb_data=0x11,0x22,0x33 on consecutive cycles, wb_addr=1,2,3, wb_en=1 each cycle.
- Mux select: alu_out=0xAA, mem_out=0x55, MemToReg=1 -> wb_data=0x55, MemToRegmux=1. Same entry with MemToReg=0 -> wb_data=0xAA.
- Backpressure/skid:
  - Hold out_ready=0, send entries A=0x01, B=0x02, C=0x03 back-to-back -> A held in M, B in S, in_ready=0 after B, C not accepted.
  - Then out_ready=1 -> outputs A, then B. in_ready returns to 1 one cycle after B leaves S.
  - C is re-sent and accepted. The full output sequence is A, B, C with no loss or duplication.
- Flush with both M and S full, plus in_valid=1 with 0x77 -> next cycle out_valid=0, wb_en=0, in_ready=1, and 0x77 never appears.
- RegWrite=0 entry with out_valid=1 and out_ready=1 -> wb_en=0.
  - WB_ON_HANDSHAKE=1 with RegWrite=1, out_ready=0 -> wb_en=0.
  - WB_ON_HANDSHAKE=0 under the same stimulus -> wb_en=1.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline-stage definitions: default widths, the stage payload
// layout and a helper for sizing flattened payload vectors.
package cpu_pipe_pkg;

  localparam int DATA_W_DEF  = 8;
  localparam int RADDR_W_DEF = 3;

  typedef struct packed {
    logic [DATA_W_DEF-1:0]  alu;
    logic [DATA_W_DEF-1:0]  mem;
    logic                   memtoreg;
    logic                   regwrite;
    logic [RADDR_W_DEF-1:0] rd;
  } stage_payload_t;

  function automatic int payload_w(input int data_w, input int raddr_w);
    return 2 * data_w + 2 + raddr_w;
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic 2-entry skid buffer: main register M drives the outputs, skid
// register S absorbs one entry when M stalls.
module pipe_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  // Handshake: a transfer happens on an edge where valid & ready are both
  // high; valid never waits on ready, and ready comes straight from S.
  logic         m_v;
  logic         s_v;
  logic [W-1:0] m_data;
  logic [W-1:0] s_data;
  logic         accept;
  logic         m_free;

  assign in_ready  = !s_v;
  assign out_valid = m_v;
  assign out_data  = m_data;
  assign accept    = in_valid & in_ready;
  assign m_free    = !m_v || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_v    <= 1'b0;
      s_v    <= 1'b0;
      m_data <= '0;
      s_data <= '0;
    end else if (flush) begin
      m_v <= 1'b0;
      s_v <= 1'b0;
    end else if (m_free) begin
      // S is full only when in_ready is low, so S and a new entry never compete for M.
      if (s_v) begin
        m_data <= s_data;
        m_v    <= 1'b1;
        s_v    <= 1'b0;
      end else if (accept) begin
        m_data <= in_data;
        m_v    <= 1'b1;
      end else begin
        m_v <= 1'b0;
      end
    end else if (accept) begin
      s_data <= in_data;
      s_v    <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: skid-buffered payload register plus the writeback
// data mux and register-file write strobe.
module mem_wb_stage
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEF,
  parameter int RADDR_W         = RADDR_W_DEF,
  parameter bit WB_ON_HANDSHAKE = 1'b1
) (
  input  logic               clk2,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic [DATA_W-1:0]  mem_out,
  input  logic               MemToReg,
  input  logic               RegWrite,
  input  logic [RADDR_W-1:0] rd_addr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  alu_in,
  output logic [DATA_W-1:0]  mem_in,
  output logic               MemToRegmux,
  output logic [DATA_W-1:0]  wb_data,
  output logic [RADDR_W-1:0] wb_addr,
  output logic               wb_en
);

  localparam int PW = payload_w(DATA_W, RADDR_W);

  typedef struct packed {
    logic [DATA_W-1:0]  alu;
    logic [DATA_W-1:0]  mem;
    logic               memtoreg;
    logic               regwrite;
    logic [RADDR_W-1:0] rd;
  } payload_t;

  payload_t in_pay;
  payload_t m_pay;
  logic     strobe_gate;

  assign in_pay = '{alu: alu_out, mem: mem_out, memtoreg: MemToReg,
                    regwrite: RegWrite, rd: rd_addr};

  pipe_skid_reg #(.W(PW)) u_skid (
    .clk       (clk2),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pay),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (m_pay)
  );

  assign alu_in      = m_pay.alu;
  assign mem_in      = m_pay.mem;
  assign MemToRegmux = m_pay.memtoreg;
  assign wb_addr     = m_pay.rd;
  assign wb_data     = m_pay.memtoreg ? m_pay.mem : m_pay.alu;

  // Stale payload after a flush is harmless because the strobe needs out_valid.
  assign strobe_gate = WB_ON_HANDSHAKE ? out_ready : 1'b1;
  assign wb_en       = out_valid & m_pay.regwrite & strobe_gate;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: a handshake-strobe and a level-strobe instance
// share stimulus; a queue model of held entries predicts every output.
module tb_mem_wb_stage;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int EW = 2 * DW + 2 + AW;

  logic          clk2 = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [DW-1:0] alu_out, mem_out;
  logic          MemToReg, RegWrite;
  logic [AW-1:0] rd_addr;

  logic          hs_in_ready, hs_out_valid, hs_mux, hs_wb_en;
  logic [DW-1:0] hs_alu_in, hs_mem_in, hs_wb_data;
  logic [AW-1:0] hs_wb_addr;
  logic          lv_in_ready, lv_out_valid, lv_mux, lv_wb_en;
  logic [DW-1:0] lv_alu_in, lv_mem_in, lv_wb_data;
  logic [AW-1:0] lv_wb_addr;

  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q[$];

  always #5 clk2 = ~clk2;

  mem_wb_stage #(.DATA_W(DW), .RADDR_W(AW), .WB_ON_HANDSHAKE(1'b1)) u_hs (
    .clk2(clk2), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_ready(hs_in_ready), .alu_out(alu_out), .mem_out(mem_out),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .rd_addr(rd_addr),
    .out_valid(hs_out_valid), .out_ready(out_ready), .alu_in(hs_alu_in),
    .mem_in(hs_mem_in), .MemToRegmux(hs_mux), .wb_data(hs_wb_data),
    .wb_addr(hs_wb_addr), .wb_en(hs_wb_en)
  );

  mem_wb_stage #(.DATA_W(DW), .RADDR_W(AW), .WB_ON_HANDSHAKE(1'b0)) u_lv (
    .clk2(clk2), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_ready(lv_in_ready), .alu_out(alu_out), .mem_out(mem_out),
    .MemToReg(MemToReg), .RegWrite(RegWrite), .rd_addr(rd_addr),
    .out_valid(lv_out_valid), .out_ready(out_ready), .alu_in(lv_alu_in),
    .mem_in(lv_mem_in), .MemToRegmux(lv_mux), .wb_data(lv_wb_data),
    .wb_addr(lv_wb_addr), .wb_en(lv_wb_en)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: outputs are compared against the head of the held-entry queue,
  // then the queue advances by the transfers this cycle's inputs cause.
  always @(negedge clk2) begin
    logic [EW-1:0] e;
    logic [DW-1:0] e_alu, e_mem;
    logic          e_mtr, e_rw;
    logic          drain, acc;
    if (rst) begin
      exp_q.delete();
    end else begin
      chk("in_ready", hs_in_ready, exp_q.size() < 2);
      chk("lv_in_ready", lv_in_ready, exp_q.size() < 2);
      chk("out_valid", hs_out_valid, exp_q.size() > 0);
      chk("lv_out_valid", lv_out_valid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
        e     = exp_q[0];
        e_alu = e[EW-1 -: DW];
        e_mem = e[EW-DW-1 -: DW];
        e_mtr = e[AW+1];
        e_rw  = e[AW];
        chk("alu_in", hs_alu_in, e_alu);
        chk("mem_in", hs_mem_in, e_mem);
        chk("MemToRegmux", hs_mux, e_mtr);
        chk("wb_data", hs_wb_data, e_mtr ? e_mem : e_alu);
        chk("wb_addr", hs_wb_addr, e[AW-1:0]);
        chk("wb_en_hs", hs_wb_en, e_rw & out_ready);
        chk("lv_payload", {lv_alu_in, lv_mem_in, lv_mux, lv_wb_addr},
            {e_alu, e_mem, e_mtr, e[AW-1:0]});
        chk("lv_wb_data", lv_wb_data, e_mtr ? e_mem : e_alu);
        chk("wb_en_lvl", lv_wb_en, e_rw);
      end else begin
        chk("wb_en_idle", hs_wb_en, 1'b0);
        chk("lv_wb_en_idle", lv_wb_en, 1'b0);
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        drain = (exp_q.size() > 0) && out_ready;
        acc   = in_valid && (exp_q.size() < 2);
        if (drain) void'(exp_q.pop_front());
        if (acc) exp_q.push_back({alu_out, mem_out, MemToReg, RegWrite, rd_addr});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk2);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] a, input logic [DW-1:0] m,
                       input logic mtr, input logic rw, input logic [AW-1:0] rd);
    in_valid = v;
    alu_out  = a;
    mem_out  = m;
    MemToReg = mtr;
    RegWrite = rw;
    rd_addr  = rd;
  endtask

  // Holds the entry on the inputs until the stage takes it.
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] m,
                      input logic mtr, input logic rw, input logic [AW-1:0] rd);
    logic acc;
    acc = 1'b0;
    drive(1'b1, a, m, mtr, rw, rd);
    for (int k = 0; k < 16 && !acc; k++) begin
      acc = hs_in_ready;
      step(1);
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    step(n);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    step(2);
    rst = 1'b0;
    chk("rst_out_valid", hs_out_valid, 1'b0);
    chk("rst_wb_en", hs_wb_en, 1'b0);
    chk("rst_in_ready", hs_in_ready, 1'b1);
    chk("rst_outputs", {hs_wb_data, hs_alu_in, hs_mem_in, hs_mux, hs_wb_addr}, '0);
    chk("rst_lv_outputs", {lv_wb_data, lv_alu_in, lv_mem_in, lv_mux, lv_wb_addr, lv_wb_en}, '0);

    out_ready = 1'b1;
    send(8'h11, 8'h00, 1'b0, 1'b1, 3'd1);
    send(8'h22, 8'h00, 1'b0, 1'b1, 3'd2);
    send(8'h33, 8'h00, 1'b0, 1'b1, 3'd3);
    idle(2);

    send(8'hAA, 8'h55, 1'b1, 1'b1, 3'd4);
    send(8'hAA, 8'h55, 1'b0, 1'b1, 3'd5);
    idle(2);

    out_ready = 1'b0;
    send(8'h01, 8'h00, 1'b0, 1'b1, 3'd1);
    send(8'h02, 8'h00, 1'b0, 1'b1, 3'd2);
    drive(1'b1, 8'h03, 8'h00, 1'b0, 1'b1, 3'd3);
    step(1);
    chk("skid_full_in_ready", hs_in_ready, 1'b0);
    out_ready = 1'b1;
    send(8'h03, 8'h00, 1'b0, 1'b1, 3'd3);
    idle(3);

    out_ready = 1'b0;
    send(8'h41, 8'h00, 1'b0, 1'b1, 3'd6);
    send(8'h42, 8'h00, 1'b0, 1'b1, 3'd7);
    drive(1'b1, 8'h77, 8'h77, 1'b0, 1'b1, 3'd7);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0);
    chk("flush_out_valid", hs_out_valid, 1'b0);
    chk("flush_wb_en", {hs_wb_en, lv_wb_en}, 2'b00);
    chk("flush_in_ready", hs_in_ready, 1'b1);
    out_ready = 1'b1;
    step(2);

    send(8'h10, 8'h00, 1'b0, 1'b0, 3'd2);
    out_ready = 1'b0;
    send(8'h20, 8'h00, 1'b0, 1'b1, 3'd3);
    idle(2);
    out_ready = 1'b1;
    idle(2);

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, DW'($urandom), DW'($urandom),
            1'($urandom), 1'($urandom), AW'($urandom));
      out_ready = $urandom_range(0, 9) < 7;
      flush     = $urandom_range(0, 19) == 0;
      rst       = $urandom_range(0, 99) == 0;
      step(1);
    end
    flush = 1'b0;
    rst = 1'b0;
    out_ready = 1'b1;
    idle(3);
    chk("final_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
